// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for control-flow resolution: opcode classes, condition codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package branch_redirect_ctrl_pkg;

    // Opcode class field, id_opcode[4:2]
    localparam logic [2:0] OPC_JMP_CLS = 3'b001;
    localparam logic [2:0] OPC_BR_CLS  = 3'b011;

    // Branch condition selector, id_opcode[1:0]
    typedef enum logic [1:0] {
        CC_EQZ = 2'b00,
        CC_NEZ = 2'b01,
        CC_LTZ = 2'b10,
        CC_GEZ = 2'b11
    } cc_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/branch_redirect_ctrl_br_cond_eval.sv
// Evaluates the zero/sign branch condition on the Rs operand.
// Latency: purely combinational.
// Backpressure: none; caller qualifies the result with rs_ready.
module br_cond_eval
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [1:0]   cc,
    input  logic [N-1:0] rs_val,
    output logic         cond_true
);

    // Select the condition encoded in the low opcode bits
    always_comb begin
        cond_true = 1'b0;
        case (cc_t'(cc))
            CC_EQZ:  cond_true = (rs_val == '0);
            CC_NEZ:  cond_true = (rs_val != '0);
            CC_LTZ:  cond_true = rs_val[N-1];
            CC_GEZ:  cond_true = ~rs_val[N-1];
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves decode-stage jumps/branches, issues a PC redirect to fetch and counts control ops.
// Latency: resolve in cycle T, redirect_valid/flush from T+1, back to IDLE no earlier than T+2.
// Backpressure: redirect held stable until redirect_ready; decode stalls while a branch Rs is not ready.
module branch_redirect_ctrl
    import branch_redirect_ctrl_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [4:0]    id_opcode,
    input  logic [N-1:0]  id_target,
    input  logic [N-1:0]  rs_val,
    input  logic          rs_ready,
    input  logic          redirect_ready,
    input  logic          cnt_clr,
    output logic          id_stall,
    output logic          flush,
    output logic          redirect_valid,
    output logic [N-1:0]  redirect_pc,
    output logic          busy,
    output logic [CW-1:0] br_cnt,
    output logic [CW-1:0] tk_cnt
);

    state_t       state;
    logic         redirect_q;
    logic [N-1:0] redirect_pc_q;

    logic is_jump;
    logic is_branch;
    logic in_idle;
    logic cond_true;
    logic resolve;
    logic resolve_taken;

    br_cond_eval #(.N(N)) u_cond (
        .cc        (id_opcode[1:0]),
        .rs_val    (rs_val),
        .cond_true (cond_true)
    );

    assign is_jump   = (id_opcode[4:2] == OPC_JMP_CLS);
    assign is_branch = (id_opcode[4:2] == OPC_BR_CLS);
    assign in_idle   = (state == ST_IDLE);

    // rs_ready gates cond_true so an unforwarded (possibly X) operand never reaches state
    assign id_stall      = in_idle & id_valid & is_branch & ~rs_ready;
    assign resolve       = in_idle & id_valid & (is_jump | (is_branch & rs_ready));
    assign resolve_taken = resolve & (is_jump | (is_branch & rs_ready & cond_true));

    assign redirect_valid = redirect_q;
    assign flush          = redirect_q;
    assign busy           = redirect_q;
    assign redirect_pc    = redirect_pc_q;

    // Redirect FSM: latch target on a taken resolve, hold until fetch accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (resolve_taken) begin
                        state         <= ST_REDIRECT;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= id_target;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state      <= ST_IDLE;
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating resolve/taken counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else if (cnt_clr) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else begin
            if (resolve && (br_cnt != '1)) begin
                br_cnt <= br_cnt + CW'(1);
            end
            if (resolve_taken && (tk_cnt != '1)) begin
                tk_cnt <= tk_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl with narrow (4-bit) counters.
// Latency: checks redirect at T+1 and return to IDLE at T+2 or later.
// Backpressure: exercises held redirects while fetch is not ready.
module tb_branch_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_opcode;
    logic [15:0] id_target;
    logic [15:0] rs_val;
    logic        rs_ready;
    logic        redirect_ready;
    logic        cnt_clr;
    logic        id_stall;
    logic        flush;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        busy;
    logic [3:0]  br_cnt;
    logic [3:0]  tk_cnt;

    int vectors;
    int miscompares;

    branch_redirect_ctrl #(.N(16), .CW(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_target      (id_target),
        .rs_val         (rs_val),
        .rs_ready       (rs_ready),
        .redirect_ready (redirect_ready),
        .cnt_clr        (cnt_clr),
        .id_stall       (id_stall),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .br_cnt         (br_cnt),
        .tk_cnt         (tk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic rv, input logic [3:0] br, input logic [3:0] tk);
        chk({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".flush"},          {31'd0, flush},          {31'd0, rv});
        chk({tag, ".busy"},           {31'd0, busy},           {31'd0, rv});
        chk({tag, ".br_cnt"},         {28'd0, br_cnt},         {28'd0, br});
        chk({tag, ".tk_cnt"},         {28'd0, tk_cnt},         {28'd0, tk});
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        id_valid       = 1'b0;
        id_opcode      = 5'b00000;
        id_target      = 16'h0000;
        rs_val         = 16'h0000;
        rs_ready       = 1'b0;
        redirect_ready = 1'b0;
        cnt_clr        = 1'b0;

        // Reset state
        #12;
        chk_state("reset", 1'b0, 4'd0, 4'd0);
        chk("reset.redirect_pc", {16'd0, redirect_pc}, 32'h0);
        chk("reset.id_stall", {31'd0, id_stall}, 32'd0);
        rst_n = 1'b1;
        tick();

        // BEQZ taken: redirect one cycle after resolve, IDLE the cycle after
        id_valid = 1'b1; id_opcode = 5'b01100; rs_val = 16'h0000; rs_ready = 1'b1;
        id_target = 16'h0040; redirect_ready = 1'b1;
        #1;
        chk("beqz.stall", {31'd0, id_stall}, 32'd0);
        chk("beqz.pre_rv", {31'd0, redirect_valid}, 32'd0);
        tick();
        chk_state("beqz.t1", 1'b1, 4'd1, 4'd1);
        chk("beqz.t1.pc", {16'd0, redirect_pc}, 32'h0040);
        id_valid = 1'b0;
        tick();
        chk_state("beqz.t2", 1'b0, 4'd1, 4'd1);

        // BNEZ on zero: not taken, counted only as resolved
        id_valid = 1'b1; id_opcode = 5'b01101; rs_val = 16'h0000; rs_ready = 1'b1;
        id_target = 16'h0F00;
        tick();
        chk_state("bnez", 1'b0, 4'd2, 4'd1);
        id_valid = 1'b0;
        tick();
        chk_state("bnez.idle", 1'b0, 4'd2, 4'd1);

        // BLTZ stalled 3 cycles on an unforwarded (X) operand, then taken
        id_valid = 1'b1; id_opcode = 5'b01110; rs_val = 16'hxxxx; rs_ready = 1'b0;
        id_target = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bltz.stall", {31'd0, id_stall}, 32'd1);
            tick();
            chk_state("bltz.held", 1'b0, 4'd2, 4'd1);
        end
        rs_ready = 1'b1; rs_val = 16'h8000;
        #1;
        chk("bltz.stall_drop", {31'd0, id_stall}, 32'd0);
        tick();
        chk_state("bltz.redir", 1'b1, 4'd3, 4'd2);
        chk("bltz.pc", {16'd0, redirect_pc}, 32'h1234);
        id_valid = 1'b0;
        tick();
        chk_state("bltz.idle", 1'b0, 4'd3, 4'd2);

        // BGEZ on a negative value: not taken
        id_valid = 1'b1; id_opcode = 5'b01111; rs_val = 16'h8000; rs_ready = 1'b1;
        id_target = 16'h5555;
        tick();
        chk_state("bgez", 1'b0, 4'd4, 4'd2);
        id_valid = 1'b0;

        // Jump with Rs not ready and fetch stalled for 4 cycles
        id_valid = 1'b1; id_opcode = 5'b00100; rs_val = 16'hxxxx; rs_ready = 1'b0;
        id_target = 16'hBEEF; redirect_ready = 1'b0;
        #1;
        chk("jmp.stall", {31'd0, id_stall}, 32'd0);
        tick();
        // Wrong-path taken BEQZ sits in decode for the whole redirect
        id_opcode = 5'b01100; rs_val = 16'h0000; rs_ready = 1'b1; id_target = 16'h0AAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_state("jmp.hold", 1'b1, 4'd5, 4'd3);
            chk("jmp.hold.pc", {16'd0, redirect_pc}, 32'hBEEF);
            chk("jmp.hold.stall", {31'd0, id_stall}, 32'd0);
            tick();
        end
        redirect_ready = 1'b1;
        #1;
        chk_state("jmp.accept", 1'b1, 4'd5, 4'd3);
        chk("jmp.accept.pc", {16'd0, redirect_pc}, 32'hBEEF);
        id_valid = 1'b0;
        tick();
        chk_state("jmp.idle", 1'b0, 4'd5, 4'd3);

        // Asynchronous reset in the middle of a redirect
        id_valid = 1'b1; id_opcode = 5'b00101; id_target = 16'h0300; redirect_ready = 1'b0;
        tick();
        chk_state("rst.pre", 1'b1, 4'd6, 4'd4);
        id_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("rst.mid", 1'b0, 4'd0, 4'd0);
        chk("rst.mid.pc", {16'd0, redirect_pc}, 32'h0);
        #2;
        rst_n = 1'b1;
        redirect_ready = 1'b1;
        tick();
        chk_state("rst.post1", 1'b0, 4'd0, 4'd0);
        tick();
        chk_state("rst.post2", 1'b0, 4'd0, 4'd0);

        // Back-to-back not-taken resolves saturate br_cnt at 4'hF
        id_valid = 1'b1; id_opcode = 5'b01101; rs_val = 16'h0000; rs_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        chk_state("sat.reach", 1'b0, 4'hF, 4'd0);
        for (int i = 0; i < 5; i++) tick();
        chk_state("sat.hold", 1'b0, 4'hF, 4'd0);
        cnt_clr = 1'b1;
        tick();
        chk_state("sat.clr", 1'b0, 4'd0, 4'd0);
        cnt_clr = 1'b0;
        tick();
        chk_state("sat.after_clr", 1'b0, 4'd1, 4'd0);
        id_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
